top_entity: RTL and testbench



---
 rtl/rtlola_pkg.sv | 22 ++
 rtl/event_fifo.sv | 60 ++++++
 rtl/top_entity.sv | 161 ++++++++++++++++
 tb/tb_top_entity.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtlola_pkg.sv
// Shared types and constants for the RTLola x/a/b monitor.
// Holds the HLC->LLC event record, LLC state codes and default timing constants.
package rtlola_pkg;

    localparam int unsigned DEF_CLK_PERIOD_NS = 2000;
    localparam int unsigned DEF_SLIDE_NS      = 500000;
    localparam int unsigned DEF_PERIOD_B_NS   = 1000000;
    localparam int unsigned DEF_QDEPTH        = 4;

    localparam logic [2:0] LLC_IDLE   = 3'd0;
    localparam logic [2:0] LLC_WINDOW = 3'd1;
    localparam logic [2:0] LLC_EVAL   = 3'd2;

    typedef struct packed {
        logic [63:0] x;
        logic        pacing_a;
        logic        pacing_b;
        logic        slide_b;
        logic [63:0] ts;
    } event_rec_t;

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO of event records between the HLC and the LLC.
// Combinational head read; pushes into a full FIFO are ignored.
module event_fifo
    import rtlola_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_QDEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  event_rec_t din,
    output event_rec_t dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    event_rec_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/top_entity.sv
// RTLola monitor: a := x (event based), b := sum of x over 2 ms at 1 kHz.
// HLC timestamps events into a FIFO; the LLC pops and evaluates one record per 3 cycles.
module top_entity
    import rtlola_pkg::*;
#(
    parameter int unsigned CLK_PERIOD_NS = DEF_CLK_PERIOD_NS,
    parameter int unsigned SLIDE_NS      = DEF_SLIDE_NS,
    parameter int unsigned PERIOD_B_NS   = DEF_PERIOD_B_NS,
    parameter int unsigned QDEPTH        = DEF_QDEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic signed [63:0] input_x,
    input  logic               new_input,
    output logic signed [63:0] a,
    output logic               aktv_a,
    output logic signed [63:0] b,
    output logic               aktv_b,
    output logic signed [63:0] hlc_timer,
    output logic signed [2:0]  llc_state,
    output logic signed [63:0] sw_b_0,
    output logic signed [63:0] sw_b_1,
    output logic signed [63:0] sw_b_2,
    output logic signed [63:0] sw_b_3,
    output logic               qPush,
    output logic               qPop,
    output logic               push_valid,
    output logic               pop_valid,
    output logic signed [63:0] llc_x,
    output logic               pacing_a,
    output logic               pacing_b,
    output logic               slide_b
);

    logic [63:0] timer_q;
    logic [63:0] next_timer;
    logic [31:0] slide_acc, slide_sum, slide_next;
    logic [31:0] period_acc, period_sum, period_next;
    event_rec_t  push_rec;
    event_rec_t  head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        llc_pa, llc_pb, llc_sb;
    logic signed [63:0] bucket0_base;
    logic signed [63:0] bucket0_next;
    logic signed [63:0] window_sum;
    logic        unused_ts;

    // Phase accumulators track timer mod SLIDE/PERIOD without a 64-bit divider.
    assign next_timer  = timer_q + 64'(CLK_PERIOD_NS);
    assign slide_sum   = slide_acc + CLK_PERIOD_NS;
    assign slide_next  = (slide_sum >= SLIDE_NS) ? slide_sum - SLIDE_NS : slide_sum;
    assign period_sum  = period_acc + CLK_PERIOD_NS;
    assign period_next = (period_sum >= PERIOD_B_NS) ? period_sum - PERIOD_B_NS : period_sum;

    assign hlc_timer  = timer_q;
    assign pacing_a   = new_input & en;
    assign slide_b    = en && (slide_next == '0) && (next_timer != '0);
    assign pacing_b   = en && (period_next == '0) && (next_timer != '0);
    assign qPush      = pacing_a | pacing_b | slide_b;
    assign push_valid = qPush & ~fifo_full;
    assign qPop       = en & ~fifo_empty & (llc_state == LLC_IDLE);

    always_comb begin
        push_rec          = '0;
        push_rec.x        = input_x;
        push_rec.pacing_a = pacing_a;
        push_rec.pacing_b = pacing_b;
        push_rec.slide_b  = slide_b;
        push_rec.ts       = next_timer;
    end

    event_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_valid),
        .pop   (qPop),
        .din   (push_rec),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The timestamp rides along for debug visibility but no stream consumes it.
    assign unused_ts = ^head.ts;

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q    <= '0;
            slide_acc  <= '0;
            period_acc <= '0;
        end else if (en) begin
            timer_q    <= next_timer;
            slide_acc  <= slide_next;
            period_acc <= period_next;
        end
    end

    // Slide clears bucket 0 before the add, so a coinciding x lands in the new bucket.
    assign bucket0_base = llc_sb ? '0 : sw_b_0;
    assign bucket0_next = llc_pa ? bucket0_base + llc_x : bucket0_base;
    assign window_sum   = sw_b_0 + sw_b_1 + sw_b_2 + sw_b_3;

    always_ff @(posedge clk) begin
        if (rst) begin
            llc_state <= LLC_IDLE;
            llc_x     <= '0;
            llc_pa    <= 1'b0;
            llc_pb    <= 1'b0;
            llc_sb    <= 1'b0;
            sw_b_0    <= '0;
            sw_b_1    <= '0;
            sw_b_2    <= '0;
            sw_b_3    <= '0;
            a         <= '0;
            b         <= '0;
            aktv_a    <= 1'b0;
            aktv_b    <= 1'b0;
            pop_valid <= 1'b0;
        end else if (en) begin
            pop_valid <= 1'b0;
            aktv_a    <= 1'b0;
            aktv_b    <= 1'b0;
            case (llc_state)
                LLC_IDLE: begin
                    if (qPop) begin
                        llc_x     <= head.x;
                        llc_pa    <= head.pacing_a;
                        llc_pb    <= head.pacing_b;
                        llc_sb    <= head.slide_b;
                        pop_valid <= 1'b1;
                        llc_state <= LLC_WINDOW;
                    end
                end
                LLC_WINDOW: begin
                    if (llc_sb) begin
                        sw_b_3 <= sw_b_2;
                        sw_b_2 <= sw_b_1;
                        sw_b_1 <= sw_b_0;
                    end
                    sw_b_0    <= bucket0_next;
                    llc_state <= LLC_EVAL;
                end
                LLC_EVAL: begin
                    if (llc_pa) begin
                        a      <= llc_x;
                        aktv_a <= 1'b1;
                    end
                    if (llc_pb) begin
                        b      <= window_sum;
                        aktv_b <= 1'b1;
                    end
                    llc_state <= LLC_IDLE;
                end
                default: llc_state <= LLC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_top_entity.sv
// Self-checking bench for top_entity: scenario tasks against a time/bucket model
// (x events keyed by timestamp; b = sum of x in the four 0.5 ms slots ending at each tick).
module tb_top_entity;

    localparam longint CLK_NS = 2000;
    localparam longint SLIDE  = 500000;
    localparam longint PER    = 1000000;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               en = 1'b1;
    logic signed [63:0] input_x = '0;
    logic               new_input = 1'b0;
    logic signed [63:0] a, b, hlc_timer, sw_b_0, sw_b_1, sw_b_2, sw_b_3, llc_x;
    logic               aktv_a, aktv_b, qPush, qPop, push_valid, pop_valid;
    logic               pacing_a, pacing_b, slide_b;
    logic signed [2:0]  llc_state;

    top_entity #(
        .CLK_PERIOD_NS (2000),
        .SLIDE_NS      (500000),
        .PERIOD_B_NS   (1000000),
        .QDEPTH        (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .input_x    (input_x),
        .new_input  (new_input),
        .a          (a),
        .aktv_a     (aktv_a),
        .b          (b),
        .aktv_b     (aktv_b),
        .hlc_timer  (hlc_timer),
        .llc_state  (llc_state),
        .sw_b_0     (sw_b_0),
        .sw_b_1     (sw_b_1),
        .sw_b_2     (sw_b_2),
        .sw_b_3     (sw_b_3),
        .qPush      (qPush),
        .qPop       (qPop),
        .push_valid (push_valid),
        .pop_valid  (pop_valid),
        .llc_x      (llc_x),
        .pacing_a   (pacing_a),
        .pacing_b   (pacing_b),
        .slide_b    (slide_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    longint             ncyc = 0;
    longint             ev_tau[$];
    logic signed [63:0] ev_x[$];
    logic signed [63:0] got_a[$];
    longint             got_a_cyc[$];
    logic signed [63:0] got_b[$];
    int                 pops = 0;
    logic               s_slide, s_pb, s_qpush, s_pv;
    longint             s_idx;

    // One clock cycle: apply inputs, sample combinational flags, then observe after the edge.
    task automatic cycle(input logic ni, input logic signed [63:0] xv, input bit accept);
        new_input = ni;
        input_x   = xv;
        #1;
        s_idx   = ncyc + 1;
        s_slide = slide_b;
        s_pb    = pacing_b;
        s_qpush = qPush;
        s_pv    = push_valid;
        if (!rst && en && ni && accept) begin
            ev_tau.push_back((ncyc + 1) * CLK_NS);
            ev_x.push_back(xv);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            ncyc = 0;
            ev_tau.delete(); ev_x.delete();
            got_a.delete(); got_a_cyc.delete(); got_b.delete();
            pops = 0;
        end else if (en) begin
            ncyc++;
            if (aktv_a) begin
                got_a.push_back(a);
                got_a_cyc.push_back(ncyc + 1);
            end
            if (aktv_b) got_b.push_back(b);
            if (pop_valid) pops++;
        end
    endtask

    function automatic logic signed [63:0] model_b(input longint k);
        logic signed [63:0] s;
        s = '0;
        foreach (ev_tau[i])
            if (ev_tau[i] <= k * PER && ev_tau[i] / SLIDE >= 2 * k - 3) s += ev_x[i];
        return s;
    endfunction

    function automatic logic signed [63:0] model_bucket(input longint key);
        logic signed [63:0] s;
        s = '0;
        foreach (ev_tau[i])
            if (ev_tau[i] / SLIDE == key) s += ev_x[i];
        return s;
    endfunction

    task automatic idle_until(input longint target);
        while (ncyc + 1 < target) cycle(1'b0, '0, 1'b1);
    endtask

    task automatic test_reset;
        logic [63:0] v [17];
        string       nm[17];
        rst = 1'b1;
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        v  = '{a, b, sw_b_0, sw_b_1, sw_b_2, sw_b_3, hlc_timer, llc_x, 64'(llc_state),
               64'(aktv_a), 64'(aktv_b), 64'(pop_valid), 64'(qPop), 64'(qPush),
               64'(push_valid), 64'(pacing_b), 64'(slide_b)};
        nm = '{"a", "b", "sw_b_0", "sw_b_1", "sw_b_2", "sw_b_3", "hlc_timer", "llc_x",
               "llc_state", "aktv_a", "aktv_b", "pop_valid", "qPop", "qPush",
               "push_valid", "pacing_b", "slide_b"};
        for (int i = 0; i < 17; i++) begin
            n_checks++;
            if (v[i] !== '0) begin
                n_fail++;
                $display("FAIL reset_%s got %0h want 0", nm[i], v[i]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_idle_ticks;
        longint sl[$];
        longint pb[$];
        for (int i = 0; i < 510; i++) begin
            cycle(1'b0, '0, 1'b1);
            if (s_slide) sl.push_back(s_idx);
            if (s_pb) pb.push_back(s_idx);
            if (ncyc == 500) begin
                n_checks++;
                if (hlc_timer !== 64'sd1000000) begin
                    n_fail++;
                    $display("FAIL idle_timer500 got %0d want 1000000", hlc_timer);
                end
            end
        end
        n_checks++;
        if (sl.size() != 2 || sl[0] != 250 || sl[1] != 500) begin
            n_fail++;
            $display("FAIL idle_slide_cycles got %p want 250,500", sl);
        end
        n_checks++;
        if (pb.size() != 1 || pb[0] != 500) begin
            n_fail++;
            $display("FAIL idle_pacing_b_cycles got %p want 500", pb);
        end
        n_checks++;
        if (got_a.size() != 0) begin
            n_fail++;
            $display("FAIL idle_aktv_a got %0d pulses want 0", got_a.size());
        end
        n_checks++;
        if (got_b.size() != 1 || got_b[0] !== model_b(1)) begin
            n_fail++;
            $display("FAIL idle_b got %0d pulses (%p) want 1 pulse of %0d", got_b.size(), got_b, model_b(1));
        end
    endtask

    task automatic test_tick_coincide;
        test_reset();
        idle_until(500);
        cycle(1'b1, 64'sd1, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);
        n_checks++;
        if (got_a.size() != 1 || got_a[0] !== 64'sd1 || got_a_cyc[0] != 504) begin
            n_fail++;
            $display("FAIL tick_a got %p at %p want 1 at 504", got_a, got_a_cyc);
        end
        n_checks++;
        if (got_b.size() != 1 || got_b[0] !== 64'sd1) begin
            n_fail++;
            $display("FAIL tick_b got %p want 1", got_b);
        end
        n_checks++;
        if (pops != 2) begin
            n_fail++;
            $display("FAIL tick_records got %0d pops want 2", pops);
        end
        n_checks++;
        if (sw_b_0 !== model_bucket(2) || sw_b_0 !== 64'sd1 || sw_b_1 !== model_bucket(1) ||
            sw_b_2 !== model_bucket(0) || sw_b_3 !== '0) begin
            n_fail++;
            $display("FAIL tick_buckets got %0d,%0d,%0d,%0d want 1,0,0,0", sw_b_0, sw_b_1, sw_b_2, sw_b_3);
        end
    endtask

    task automatic test_sequence;
        for (int v = 2; v <= 9; v++) begin
            idle_until(500 + 250 * longint'(v - 1));
            cycle(1'b1, 64'(v), 1'b1);
            for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
            if (v == 3) begin
                n_checks++;
                if (sw_b_0 !== 64'sd3 || sw_b_1 !== 64'sd2 || sw_b_2 !== 64'sd1 || sw_b_3 !== 64'sd0) begin
                    n_fail++;
                    $display("FAIL seq_buckets_2ms got %0d,%0d,%0d,%0d want 3,2,1,0", sw_b_0, sw_b_1, sw_b_2, sw_b_3);
                end
            end
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);
        n_checks++;
        if (got_b.size() < 4 || got_b[1] !== 64'sd6 || got_b[2] !== 64'sd14 || got_b[3] !== 64'sd22) begin
            n_fail++;
            $display("FAIL seq_b_2_3_4ms got %p want 1,6,14,22,...", got_b);
        end
        foreach (got_b[k]) begin
            n_checks++;
            if (got_b[k] !== model_b(k + 1)) begin
                n_fail++;
                $display("FAIL seq_b_tick%0d got %0d want %0d", k + 1, got_b[k], model_b(k + 1));
            end
        end
        n_checks++;
        if (got_a.size() != ev_x.size()) begin
            n_fail++;
            $display("FAIL seq_a_count got %0d want %0d", got_a.size(), ev_x.size());
        end else begin
            foreach (got_a[i]) begin
                n_checks++;
                if (got_a[i] !== ev_x[i] || got_a_cyc[i] != ev_tau[i] / CLK_NS + 4) begin
                    n_fail++;
                    $display("FAIL seq_a%0d got %0d at %0d want %0d at %0d", i, got_a[i], got_a_cyc[i],
                             ev_x[i], ev_tau[i] / CLK_NS + 4);
                end
            end
        end
    endtask

    task automatic test_isolated_negative;
        longint c;
        longint key;
        c = ((ncyc + 1) / 250 + 1) * 250 + 100;
        idle_until(c);
        key = c * CLK_NS / SLIDE;
        cycle(1'b1, -64'sd5, 1'b1);
        n_checks++;
        if (qPop !== 1'b1 || llc_state !== 3'sd0) begin
            n_fail++;
            $display("FAIL iso_t1 got qPop=%b state=%0d want 1,0", qPop, llc_state);
        end
        cycle(1'b0, '0, 1'b1);
        n_checks++;
        if (llc_state !== 3'sd1 || pop_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL iso_t2 got state=%0d pop_valid=%b want 1,1", llc_state, pop_valid);
        end
        cycle(1'b0, '0, 1'b1);
        n_checks++;
        if (llc_state !== 3'sd2) begin
            n_fail++;
            $display("FAIL iso_t3 got state=%0d want 2", llc_state);
        end
        cycle(1'b0, '0, 1'b1);
        n_checks++;
        if (aktv_a !== 1'b1 || a !== -64'sd5 || aktv_b !== 1'b0 || llc_state !== 3'sd0) begin
            n_fail++;
            $display("FAIL iso_t4 got aktv_a=%b a=%0d aktv_b=%b state=%0d want 1,-5,0,0",
                     aktv_a, a, aktv_b, llc_state);
        end
        n_checks++;
        if (sw_b_0 !== model_bucket(key)) begin
            n_fail++;
            $display("FAIL iso_bucket0 got %0d want %0d", sw_b_0, model_bucket(key));
        end
    endtask

    task automatic test_overflow;
        int base;
        base = got_a.size();
        idle_until(((ncyc + 1) / 250 + 1) * 250 + 60);
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, 64'(100 + i), i != 6);
            n_checks++;
            if (s_pv !== (i != 6) || s_qpush !== 1'b1) begin
                n_fail++;
                $display("FAIL ovf_push%0d got push_valid=%b qPush=%b want %b,1", i, s_pv, s_qpush, i != 6);
            end
        end
        for (int i = 0; i < 25; i++) cycle(1'b0, '0, 1'b1);
        n_checks++;
        if (got_a.size() != base + 6) begin
            n_fail++;
            $display("FAIL ovf_count got %0d want %0d", got_a.size() - base, 6);
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (got_a[base + i] !== 64'(100 + i) ||
                    (i > 0 && got_a_cyc[base + i] - got_a_cyc[base + i - 1] != 3)) begin
                    n_fail++;
                    $display("FAIL ovf_order%0d got %0d at %0d want %0d 3 cycles after previous",
                             i, got_a[base + i], got_a_cyc[base + i], 100 + i);
                end
            end
        end
    endtask

    task automatic test_random;
        test_reset();
        while (ncyc < 1600) begin
            for (int g = $urandom_range(3, 10); g > 0; g--) cycle(1'b0, '0, 1'b1);
            cycle(1'b1, {$urandom(), $urandom()}, 1'b1);
            n_checks++;
            if (hlc_timer !== ncyc * CLK_NS) begin
                n_fail++;
                $display("FAIL rnd_timer got %0d want %0d", hlc_timer, ncyc * CLK_NS);
            end
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);
        n_checks++;
        if (got_a.size() != ev_x.size() || got_b.size() != ncyc * CLK_NS / PER - (ncyc % 500 < 4 ? 1 : 0)) begin
            n_fail++;
            $display("FAIL rnd_counts got a=%0d b=%0d want a=%0d", got_a.size(), got_b.size(), ev_x.size());
        end
        foreach (got_a[i]) begin
            if (i < ev_x.size()) begin
                n_checks++;
                if (got_a[i] !== ev_x[i]) begin
                    n_fail++;
                    $display("FAIL rnd_a%0d got %0d want %0d", i, got_a[i], ev_x[i]);
                end
            end
        end
        foreach (got_b[k]) begin
            n_checks++;
            if (got_b[k] !== model_b(k + 1)) begin
                n_fail++;
                $display("FAIL rnd_b_tick%0d got %0d want %0d", k + 1, got_b[k], model_b(k + 1));
            end
        end
    endtask

    task automatic test_enable_then_reset;
        longint hold;
        idle_until(((ncyc + 1) / 250 + 1) * 250 + 30);
        cycle(1'b1, 64'sd77, 1'b1);
        hold = ncyc * CLK_NS;
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 64'sd5, 1'b1);
            n_checks++;
            if (s_qpush !== 1'b0 || qPop !== 1'b0 || hlc_timer !== hold || llc_state !== 3'sd0) begin
                n_fail++;
                $display("FAIL en0_hold%0d got qPush=%b qPop=%b timer=%0d state=%0d want 0,0,%0d,0",
                         i, s_qpush, qPop, hlc_timer, llc_state, hold);
            end
        end
        en = 1'b1;
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        n_checks++;
        if (llc_state !== 3'sd2 || llc_x !== 64'sd77) begin
            n_fail++;
            $display("FAIL en1_resume got state=%0d llc_x=%0d want 2,77", llc_state, llc_x);
        end
        test_reset();
    endtask

    initial begin
        test_reset();
        test_idle_ticks();
        test_tick_coincide();
        test_sequence();
        test_isolated_negative();
        test_overflow();
        test_random();
        test_enable_then_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
